// File: rtl/usb_rx_unstuff_shift.sv
// usb_rx_unstuff_shift: removes USB stuffed zeros from the NRZI-decoded
// bit stream and assembles the data bits LSB-first into bytes.
// Optional build macro USB_RX_STICKY_STUFF_ERR_EN: when defined, stuff_err
// latches on a violation until rx_clear or reset. When undefined, it is a
// one-cycle pulse.
module usb_rx_unstuff_shift #(
    parameter int DATA_W    = 8,
    parameter int STUFF_LEN = 6
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      d_sent,
    input  logic                      shift_enable,
    input  logic                      eop,
    input  logic                      rx_clear,
    output logic [DATA_W-1:0]         rx_byte,
    output logic                      byte_valid,
    output logic                      stuff_err,
    output logic [$clog2(DATA_W)-1:0] bit_cnt
);
    localparam int CNT_W  = $clog2(DATA_W);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    logic [DATA_W-1:0] sr;
    logic [ONES_W-1:0] ones_cnt;
    logic [DATA_W-1:0] sr_next;
    logic              stuff_slot;
    logic              last_bit;
    logic              violation;

    // After STUFF_LEN consecutive data 1s, the next sample is the stuffed slot.
    assign sr_next    = {d_sent, sr[DATA_W-1:1]};
    assign stuff_slot = (ones_cnt == ONES_W'(STUFF_LEN));
    assign last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));
    assign violation  = !rx_clear && shift_enable && !eop && stuff_slot && d_sent;

    // Shift/unstuff datapath. Priority: rx_clear, then eop, then data/stuff sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr         <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else if (rx_clear) begin
            sr         <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (shift_enable && eop) begin
                // Abandon the partial byte; the shift register is fully
                // overwritten before the next completion anyway.
                ones_cnt <= '0;
                bit_cnt  <= '0;
            end else if (shift_enable) begin
                if (stuff_slot) begin
                    // Stuffed bit: dropped, only the run of 1s restarts.
                    ones_cnt <= '0;
                end else begin
                    sr       <= sr_next;
                    ones_cnt <= d_sent ? ones_cnt + 1'b1 : '0;
                    if (last_bit) begin
                        bit_cnt    <= '0;
                        rx_byte    <= sr_next;
                        byte_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Bit-stuff violation flag: a 1 seen in the stuffed slot.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stuff_err <= 1'b0;
        end else if (rx_clear) begin
            stuff_err <= 1'b0;
        end else begin
`ifdef USB_RX_STICKY_STUFF_ERR_EN
            if (violation) stuff_err <= 1'b1;
`else
            stuff_err <= violation;
`endif
        end
    end
endmodule

// File: doc/usb_rx_unstuff_shift.md
Name: usb_rx_unstuff_shift

Overview:
- Downstream consumer of the NRZI decode stage in the USB receive path.
- Takes the decoded bit stream (`d_sent`, qualified by `shift_enable`) and removes stuffed zeros.
- Assembles bits LSB-first into bytes and presents each completed byte with a one-cycle valid strobe to the RX packet controller.
- Flags bit-stuffing violations.

Parameters:
- DATA_W, 8: width of the assembled word in bits.
- STUFF_LEN, 6: number of consecutive 1s after which one stuffed 0 is expected.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- n_rst  input  1  asynchronous active-low reset
- d_sent  input  1  decoded bit from the NRZI decoder; idle value 1
- shift_enable  input  1  one-cycle strobe marking the bit-sample cycle
- eop  input  1  end-of-packet detected; only acted on when shift_enable=1
- rx_clear  input  1  synchronous clear of alignment and counters from the RX controller (start of packet)
- rx_byte  output  DATA_W  last completed byte, LSB = first received bit
- byte_valid  output  1  one-cycle pulse: rx_byte updated this cycle
- stuff_err  output  1  bit-stuff violation indication
- bit_cnt  output  $clog2(DATA_W)  data bits collected in the current byte (0..DATA_W-1)

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk.
- Reset values: rx_byte=0, byte_valid=0, stuff_err=0, bit_cnt=0, ones counter=0, shift register=0.
- Internal state:
  - shift register sr[DATA_W-1:0]
  - ones_cnt, range 0..STUFF_LEN
  - bit_cnt
- Priority per cycle, highest first: rx_clear > (shift_enable & eop) > (shift_enable & !eop) > hold.
- rx_clear=1:
  - bit_cnt=0, ones_cnt=0, sr=0.
  - byte_valid=0.
  - Non-sticky build: stuff_err=0.
  - rx_byte is held.
- shift_enable=1, eop=1:
  - bit_cnt=0, ones_cnt=0.
  - Partial byte discarded; no byte_valid.
  - d_sent is ignored.
- shift_enable=1, eop=0, ones_cnt==STUFF_LEN (stuffed-bit slot):
  - The bit is discarded: no shift, bit_cnt unchanged, ones_cnt=0.
  - If d_sent=1, stuff_err asserts the next cycle.
- shift_enable=1, eop=0, ones_cnt<STUFF_LEN (data bit):
  - sr <= {d_sent, sr[DATA_W-1:1]}.
  - ones_cnt <= d_sent ? ones_cnt+1 : 0.
  - If bit_cnt==DATA_W-1: bit_cnt wraps to 0, rx_byte <= {d_sent, sr[DATA_W-1:1]}, byte_valid=1 in the next cycle.
  - Otherwise bit_cnt increments.
- ones_cnt carries across byte boundaries; stuffing is independent of byte alignment.
- byte_valid:
  - Registered; high exactly one cycle after the shift_enable cycle of the final data bit.
  - Never high for two consecutive cycles.
  - rx_byte is stable until the next completion.
- shift_enable=0: all state held; byte_valid and non-sticky stuff_err return to 0.
- The stuffed slot completing at a byte boundary does not produce a byte; only data bits count.
- Reset mid-byte: all state returns to reset values immediately; no byte_valid is emitted.

Optional Feature:
- Macro: USB_RX_STICKY_STUFF_ERR_EN.
- Defined: stuff_err is sticky. It sets on a violation and stays 1 until rx_clear or reset. eop does not clear it.
- Undefined: stuff_err is a one-cycle pulse, high only the cycle after the violating sample.
- Data-path behaviour is identical in both builds.

Test Plan:
- Bits 1,0,1,0,0,1,0,1 on 8 shift_enables -> one cycle after the 8th: byte_valid=1, rx_byte=0xA5, bit_cnt=0, stuff_err=0.
- Bits 1,1,1,1,1,1,0,1,1 on 9 shift_enables -> the 0 is dropped; one byte_valid with rx_byte=0xFF after the 9th sample; no stuff_err.
- Seven consecutive 1s -> 7th sample dropped; stuff_err=1 for one cycle (non-sticky) or held until rx_clear (sticky build); bit_cnt=6.
- 3 data bits then shift_enable+eop -> no byte_valid, bit_cnt=0; following bits 0x3C LSB-first -> rx_byte=0x3C.
- rx_clear and shift_enable (d_sent=1) in the same cycle at bit_cnt=5 -> bit_cnt=0, ones_cnt=0, no shift.
- n_rst pulsed low at bit_cnt=4 -> all outputs 0 immediately; next 8 bits 0x81 LSB-first -> rx_byte=0x81.
